apb3_cmd_master: RTL and testbench

APB3_CMD_MASTER -- requirements
Module: apb3_cmd_master

---
 rtl/apb3_pkg.sv | 14 +
 rtl/apb3_timeout_cnt.sv | 30 +++
 rtl/apb3_cmd_master.sv | 98 +++++++++
 tb/tb_apb3_cmd_master.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/apb3_pkg.sv
// rtl/apb3_pkg.sv - shared FSM state type and defaults for the APB3 command master
package apb3_pkg;

    localparam int TIMEOUT_CYCLES_DEF = 16;
    localparam int CNT_WIDTH_DEF      = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb3_state_t;

endpackage

// File: rtl/apb3_timeout_cnt.sv
// rtl/apb3_timeout_cnt.sv - ACCESS-phase wait counter with expiry detect
module apb3_timeout_cnt #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] limit,
    output logic                 expired
);

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] count_q;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + ONE;
        end
    end

    // Expires on the wait cycle whose increment would reach the limit; limit 0 never expires.
    assign expired = enable && (limit != '0) && (count_q == limit - ONE);

endmodule

// File: rtl/apb3_cmd_master.sv
// rtl/apb3_cmd_master.sv - command/response to APB3 master bridge with access timeout
module apb3_cmd_master
    import apb3_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int CNT_WIDTH      = CNT_WIDTH_DEF
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_write,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic        PWRITE,
    output logic        PSEL,
    output logic        PENABLE,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);

    apb3_state_t state_q, state_d;
    logic        expired;

    apb3_timeout_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_timeout (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .clear   (state_q == ST_SETUP),
        .enable  ((state_q == ST_ACCESS) && !PREADY),
        .limit   (LIMIT),
        .expired (expired)
    );

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_valid) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (PREADY || expired) state_d = ST_RESP;
            ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Handshake and APB strobes decode straight from the state register.
    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign PSEL      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign PENABLE   = (state_q == ST_ACCESS);

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            PADDR       <= '0;
            PWDATA      <= '0;
            PWRITE      <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && req_valid) begin
                PADDR  <= req_addr;
                PWDATA <= req_wdata;
                PWRITE <= req_write;
            end
            if (state_q == ST_ACCESS) begin
                // A ready slave wins over a timeout expiring in the same cycle.
                if (PREADY) begin
                    rsp_rdata   <= PWRITE ? 32'h0 : PRDATA;
                    rsp_err     <= PSLVERR;
                    rsp_timeout <= 1'b0;
                end else if (expired) begin
                    rsp_rdata   <= 32'h0;
                    rsp_err     <= 1'b1;
                    rsp_timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb3_cmd_master.sv
// tb/tb_apb3_cmd_master.sv - directed self-checking bench for apb3_cmd_master
module tb_apb3_cmd_master;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;

    int n_chk = 0;
    int n_err = 0;

    apb3_cmd_master #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(8)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_write(req_write),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic wr);
        req_valid = 1'b1; req_addr = addr; req_wdata = wdata; req_write = wr;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_write = 1'b0;
        rsp_ready = 1'b0; PRDATA = 32'h0; PREADY = 1'b1; PSLVERR = 1'b0;
        tick(); tick();
        PRESETn = 1'b1;
        n_chk++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready: got %0h exp 1", req_ready); end
        n_chk++; if (PSEL !== 1'b0) begin n_err++; $display("FAIL rst_psel: got %0h exp 0", PSEL); end
        n_chk++; if (PENABLE !== 1'b0) begin n_err++; $display("FAIL rst_penable: got %0h exp 0", PENABLE); end
        n_chk++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %0h exp 0", rsp_valid); end
        n_chk++; if ({PADDR, PWDATA, PWRITE} !== 65'h0) begin n_err++; $display("FAIL rst_apb_regs: got %0h exp 0", {PADDR, PWDATA, PWRITE}); end
        n_chk++; if ({rsp_rdata, rsp_err, rsp_timeout} !== 34'h0) begin n_err++; $display("FAIL rst_rsp_regs: got %0h exp 0", {rsp_rdata, rsp_err, rsp_timeout}); end
    endtask

    task automatic test_write();
        PREADY = 1'b1; PRDATA = 32'hDEAD_BEEF;
        issue(32'h0000_0000, 32'h0000_1234, 1'b1);
        n_chk++; if ({PSEL, PENABLE} !== 2'b10) begin n_err++; $display("FAIL wr_setup_strobes: got %b exp 10", {PSEL, PENABLE}); end
        n_chk++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL wr_setup_req_ready: got %0h exp 0", req_ready); end
        n_chk++; if ({PWRITE, PWDATA} !== {1'b1, 32'h0000_1234}) begin n_err++; $display("FAIL wr_setup_data: got %0h exp 100001234", {PWRITE, PWDATA}); end
        tick();
        n_chk++; if ({PSEL, PENABLE} !== 2'b11) begin n_err++; $display("FAIL wr_access_strobes: got %b exp 11", {PSEL, PENABLE}); end
        n_chk++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL wr_access_rsp_valid: got %0h exp 0", rsp_valid); end
        tick();
        n_chk++; if ({PSEL, PENABLE, rsp_valid} !== 3'b001) begin n_err++; $display("FAIL wr_resp_strobes: got %b exp 001", {PSEL, PENABLE, rsp_valid}); end
        n_chk++; if ({rsp_rdata, rsp_err, rsp_timeout} !== 34'h0) begin n_err++; $display("FAIL wr_resp_fields: got %0h exp 0", {rsp_rdata, rsp_err, rsp_timeout}); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_chk++; if ({req_ready, rsp_valid} !== 2'b10) begin n_err++; $display("FAIL wr_done_idle: got %b exp 10", {req_ready, rsp_valid}); end
        n_chk++; if (PWDATA !== 32'h0000_1234) begin n_err++; $display("FAIL wr_idle_hold: got %0h exp 1234", PWDATA); end
    endtask

    task automatic test_read_wait();
        PREADY = 1'b0; PRDATA = 32'h0000_ABCD;
        issue(32'h0000_0004, 32'h0, 1'b0);
        n_chk++; if ({PSEL, PENABLE} !== 2'b10) begin n_err++; $display("FAIL rd_setup_strobes: got %b exp 10", {PSEL, PENABLE}); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++; if ({PSEL, PENABLE, PWRITE, PADDR} !== {3'b110, 32'h0000_0004}) begin n_err++; $display("FAIL rd_access_%0d: got %0h exp 600000004", i, {PSEL, PENABLE, PWRITE, PADDR}); end
            if (i == 3) PREADY = 1'b1;
        end
        tick();
        n_chk++; if ({rsp_valid, PSEL} !== 2'b10) begin n_err++; $display("FAIL rd_resp_valid: got %b exp 10", {rsp_valid, PSEL}); end
        n_chk++; if ({rsp_rdata, rsp_err, rsp_timeout} !== {32'h0000_ABCD, 2'b00}) begin n_err++; $display("FAIL rd_resp_fields: got %0h exp 2af34", {rsp_rdata, rsp_err, rsp_timeout}); end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    endtask

    task automatic test_timeout();
        PREADY = 1'b0; PRDATA = 32'h5555_5555;
        issue(32'h0000_0008, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++; if ({PSEL, PENABLE} !== 2'b11) begin n_err++; $display("FAIL to_access_%0d: got %b exp 11", i, {PSEL, PENABLE}); end
        end
        tick();
        n_chk++; if ({rsp_valid, PSEL, PENABLE} !== 3'b100) begin n_err++; $display("FAIL to_resp_strobes: got %b exp 100", {rsp_valid, PSEL, PENABLE}); end
        n_chk++; if ({rsp_rdata, rsp_err, rsp_timeout} !== {32'h0, 2'b11}) begin n_err++; $display("FAIL to_resp_fields: got %0h exp 3", {rsp_rdata, rsp_err, rsp_timeout}); end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        PREADY = 1'b1;
    endtask

    task automatic test_slverr_stall();
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'h0000_0077;
        issue(32'h0000_000C, 32'h0, 1'b0);
        tick(); tick();
        PSLVERR = 1'b0; PRDATA = 32'h1111_1111;
        n_chk++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110) begin n_err++; $display("FAIL se_resp_flags: got %b exp 110", {rsp_valid, rsp_err, rsp_timeout}); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_chk++; if ({req_ready, rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {4'b0110, 32'h0000_0077}) begin n_err++; $display("FAIL se_stall_%0d: got %0h exp 600000077", i, {req_ready, rsp_valid, rsp_err, rsp_timeout, rsp_rdata}); end
        end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        PREADY = 1'b0;
        issue(32'h0000_0010, 32'h0000_00AA, 1'b1);
        tick();
        n_chk++; if (PENABLE !== 1'b1) begin n_err++; $display("FAIL rm_in_access: got %0h exp 1", PENABLE); end
        PRESETn = 1'b0; tick(); PRESETn = 1'b1;
        n_chk++; if ({PSEL, rsp_valid, req_ready} !== 3'b001) begin n_err++; $display("FAIL rm_after_reset: got %b exp 001", {PSEL, rsp_valid, req_ready}); end
        PREADY = 1'b1;
        issue(32'h0000_0020, 32'h0000_CAFE, 1'b1);
        tick(); tick();
        n_chk++; if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b100, 32'h0}) begin n_err++; $display("FAIL rm_followup_resp: got %0h exp 400000000", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}); end
        n_chk++; if ({PADDR, PWDATA} !== {32'h0000_0020, 32'h0000_CAFE}) begin n_err++; $display("FAIL rm_followup_regs: got %0h exp 200000cafe", {PADDR, PWDATA}); end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        PREADY = 1'b1; rsp_ready = 1'b1; req_valid = 1'b1; req_write = 1'b1;
        req_addr = 32'h0000_0030; req_wdata = 32'h0000_0001;
        tick();
        req_addr = 32'h0000_0034; req_wdata = 32'h0000_0002;
        tick(); tick();
        n_chk++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL b2b_first_rsp: got %0h exp 1", rsp_valid); end
        tick();
        n_chk++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_4th: got %0h exp 1", req_ready); end
        tick();
        req_valid = 1'b0;
        n_chk++; if ({PSEL, PENABLE, PADDR} !== {2'b10, 32'h0000_0034}) begin n_err++; $display("FAIL b2b_second_setup: got %0h exp 200000034", {PSEL, PENABLE, PADDR}); end
        tick(); tick(); tick();
        rsp_ready = 1'b0;
        n_chk++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_final_idle: got %0h exp 1", req_ready); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_timeout();
        test_slverr_stall();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
